// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave timer controller.
//   - FSM state encoding (3-bit, legacy-compatible localparams)
//   - BCD digit width and per-digit borrow reload limits
//   - presc_width(): counter width needed to count 0..div-1 (at least 1 bit)
package microwave_pkg;

    localparam int unsigned BCD_W = 4;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSet   = 3'd1;
    localparam logic [2:0] StCook  = 3'd2;
    localparam logic [2:0] StPause = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    // Value a digit reloads to when it borrows from its left neighbour.
    localparam logic [BCD_W-1:0] BCD_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_TENS_MAX = 4'd5;

    function automatic int unsigned presc_width(input int unsigned div);
        if (div < 3) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_down_counter_4d.sv
// Four-digit MM:SS BCD register with keypad shift-in and 1-step countdown.
// Ports:
//   clk, rst                  clock, async active-high reset (digits -> 0)
//   clr                       synchronous clear to 0000 (highest priority)
//   shift_en, shift_digit     shift digits left, new digit enters sec_ones
//   dec                       decrement by one second with MM:SS borrows
//   min_tens..sec_ones        current digits
//   zero                      all digits are 0
//   next_zero                 a decrement now would yield 0000
module bcd_down_counter_4d
    import microwave_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic [BCD_W-1:0] shift_digit,
    input  logic             dec,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             zero,
    output logic             next_zero
);

    logic [BCD_W-1:0] mt_q, mt_d;
    logic [BCD_W-1:0] mo_q, mo_d;
    logic [BCD_W-1:0] st_q, st_d;
    logic [BCD_W-1:0] so_q, so_d;

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (clr) begin
            mt_d = '0;
            mo_d = '0;
            st_d = '0;
            so_d = '0;
        end else if (shift_en) begin
            mt_d = mo_q;
            mo_d = st_q;
            st_d = so_q;
            so_d = shift_digit;
        end else if (dec) begin
            // A keyed-in sec_tens of 6-9 just counts down; only a 0 borrows.
            if (so_q != '0) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = BCD_ONES_MAX;
                if (st_q != '0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = BCD_TENS_MAX;
                    if (mo_q != '0) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        mo_d = BCD_ONES_MAX;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens  = mt_q;
    assign min_ones  = mo_q;
    assign sec_tens  = st_q;
    assign sec_ones  = so_q;
    assign zero      = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == '0);
    assign next_zero = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == 4'd1);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave oven sequencer: keypad entry of MM:SS, 1 Hz countdown, magnetron
// enable while cooking, timer_done hold after expiry.
// Ports:
//   clk, rst                   clock, async active-high reset
//   startN, stopN, clearN      active-low button levels (clk-synchronous)
//   door_closed                1 = door closed
//   key_valid, key_digit       keypad strobe and BCD digit (10-15 ignored)
//   mag_on                     registered magnetron enable
//   timer_done                 registered, high throughout DONE
//   min_tens..sec_ones         BCD display digits
//   state_o                    current FSM state
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DONE_HOLD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startN,
    input  logic             stopN,
    input  logic             clearN,
    input  logic             door_closed,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    output logic             mag_on,
    output logic             timer_done,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [2:0]       state_o
);

    localparam int unsigned   PW         = presc_width(TICK_DIV);
    localparam int unsigned   HW         = presc_width(DONE_HOLD + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(DONE_HOLD - 1);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          start_q, stop_q, clear_q;
    logic          mag_on_q, mag_on_d;
    logic          timer_done_q, timer_done_d;

    logic start_ev, stop_ev, clear_ev, key_ok, tick;
    logic cnt_clr, cnt_shift, cnt_dec, cnt_zero, cnt_next_zero;

    // Falling edge against the registered level: a held button fires once.
    assign start_ev = start_q & ~startN;
    assign stop_ev  = stop_q & ~stopN;
    assign clear_ev = clear_q & ~clearN;
    assign key_ok   = key_valid && (key_digit <= 4'd9);
    // Prescaler is held at 0 outside COOK/DONE, so this never fires there.
    assign tick     = (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        cnt_clr   = 1'b0;
        cnt_shift = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            StIdle: begin
                if (clear_ev || stop_ev) begin
                    cnt_clr = 1'b1;
                end else if (key_ok) begin
                    cnt_shift = 1'b1;
                    state_d   = StSet;
                end
            end
            StSet: begin
                if (clear_ev || stop_ev) begin
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (start_ev && door_closed && !cnt_zero) begin
                    state_d = StCook;
                end else if (key_ok) begin
                    cnt_shift = 1'b1;
                end
            end
            StCook: begin
                if (clear_ev) begin
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (stop_ev || !door_closed) begin
                    // Any coincident tick is dropped.
                    state_d = StPause;
                end else if (tick) begin
                    cnt_dec = 1'b1;
                    if (cnt_next_zero) begin
                        state_d = StDone;
                    end
                end
            end
            StPause: begin
                if (clear_ev || stop_ev) begin
                    cnt_clr = 1'b1;
                    state_d = StIdle;
                end else if (start_ev && door_closed) begin
                    state_d = StCook;
                end
            end
            StDone: begin
                hold_d = hold_q;
                if (clear_ev || stop_ev) begin
                    state_d = StIdle;
                end else if (tick) begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Runs only while staying in COOK/DONE; any state change restarts it.
        if ((state_q == StCook || state_q == StDone) && (state_d == state_q)) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end else begin
            presc_d = '0;
        end

        mag_on_d     = (state_d == StCook);
        timer_done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            presc_q      <= '0;
            hold_q       <= '0;
            start_q      <= 1'b1;
            stop_q       <= 1'b1;
            clear_q      <= 1'b1;
            mag_on_q     <= 1'b0;
            timer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            hold_q       <= hold_d;
            start_q      <= startN;
            stop_q       <= stopN;
            clear_q      <= clearN;
            mag_on_q     <= mag_on_d;
            timer_done_q <= timer_done_d;
        end
    end

    bcd_down_counter_4d u_counter (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr),
        .shift_en    (cnt_shift),
        .shift_digit (key_digit),
        .dec         (cnt_dec),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .zero        (cnt_zero),
        .next_zero   (cnt_next_zero)
    );

    assign mag_on     = mag_on_q;
    assign timer_done = timer_done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed + randomized bench for microwave_timer_ctrl (TICK_DIV=4, DONE_HOLD=3).
// Reference model keeps the cook time as minutes/seconds integers and the
// controller mode as a plain state code.
module tb_microwave_timer_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DONE_HOLD = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       startN, stopN, clearN, door_closed, key_valid;
    logic [3:0] key_digit;
    logic       mag_on, timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    int m_state;
    int m_hold;
    int md[4];

    always #5 clk = ~clk;

    microwave_timer_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .DONE_HOLD (DONE_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .startN      (startN),
        .stopN       (stopN),
        .clearN      (clearN),
        .door_closed (door_closed),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .state_o     (state_o)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit m_zero();
        return (md[0] == 0) && (md[1] == 0) && (md[2] == 0) && (md[3] == 0);
    endfunction

    task automatic m_to_idle();
        m_state = M_IDLE;
        md      = '{0, 0, 0, 0};
    endtask

    task automatic check(input string tag);
        logic [4:0]  exp_ctl;
        logic [15:0] exp_dig;
        exp_ctl = {3'(m_state), m_state == M_COOK, m_state == M_DONE};
        exp_dig = {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
        total++;
        assert ({state_o, mag_on, timer_done} === exp_ctl)
        else begin
            bad++;
            $error("FAIL %s state/mag/done: observed=%b expected=%b", tag,
                   {state_o, mag_on, timer_done}, exp_ctl);
        end
        total++;
        assert ({min_tens, min_ones, sec_tens, sec_ones} === exp_dig)
        else begin
            bad++;
            $error("FAIL %s digits: observed=%h expected=%h", tag,
                   {min_tens, min_ones, sec_tens, sec_ones}, exp_dig);
        end
    endtask

    // One second of model time elapses.
    task automatic model_tick();
        int mins, secs;
        if (m_state == M_COOK) begin
            mins = md[0] * 10 + md[1];
            secs = md[2] * 10 + md[3];
            if (secs > 0) begin
                secs--;
            end else begin
                mins--;
                secs = 59;
            end
            md = '{mins / 10, mins % 10, secs / 10, secs % 10};
            if (mins == 0 && secs == 0) begin
                m_state = M_DONE;
                m_hold  = 0;
            end
        end else if (m_state == M_DONE) begin
            m_hold++;
            if (m_hold == DONE_HOLD) m_state = M_IDLE;
        end
    endtask

    task automatic run_ticks(input int n, input string tag);
        repeat (n) begin
            cyc(TICK_DIV);
            model_tick();
            check(tag);
        end
    endtask

    task automatic key(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        cyc(1);
        key_valid = 1'b0;
        if (d <= 9 && (m_state == M_IDLE || m_state == M_SET)) begin
            md[0]   = md[1];
            md[1]   = md[2];
            md[2]   = md[3];
            md[3]   = d;
            m_state = M_SET;
        end
    endtask

    task automatic press_start();
        startN = 1'b0;
        cyc(1);
        startN = 1'b1;
        if ((m_state == M_SET && door_closed && !m_zero()) ||
            (m_state == M_PAUSE && door_closed)) begin
            m_state = M_COOK;
        end
    endtask

    task automatic press_clear();
        clearN = 1'b0;
        cyc(1);
        clearN = 1'b1;
        m_to_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        rst = 1'b1; startN = 1'b1; stopN = 1'b1; clearN = 1'b1;
        door_closed = 1'b1; key_valid = 1'b0; key_digit = 4'd0;
        m_to_idle();
        m_hold = 0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("reset");

        // Keypad entry and invalid digit
        key(1); key(2); key(3);
        check("keys_123");
        key(12);
        check("key_invalid");
        press_clear();
        check("clear_set");

        // Full countdown 0005 with DONE hold
        key(0); key(0); key(0); key(5);
        press_start();
        check("start_0005");
        cyc(TICK_DIV - 1);
        check("no_early_tick");
        cyc(1);
        model_tick();
        check("first_tick");
        run_ticks(4, "count_0005");
        run_ticks(DONE_HOLD, "done_hold");

        // Borrow chains
        key(1); key(0); key(0);
        press_start();
        run_ticks(1, "borrow_0100");
        press_clear();
        key(1); key(0); key(0); key(0);
        press_start();
        run_ticks(2, "borrow_1000");
        press_clear();
        key(9); key(0);
        press_start();
        run_ticks(2, "count_0090");
        press_clear();

        // Door open on a tick cycle: tick dropped, PAUSE, resume
        key(3); key(0);
        press_start();
        run_ticks(2, "cook_0030");
        cyc(TICK_DIV - 1);
        door_closed = 1'b0;
        cyc(1);
        m_state = M_PAUSE;
        check("door_open_tick_dropped");
        cyc(5);
        check("pause_frozen");
        door_closed = 1'b1;
        cyc(3);
        check("door_closed_no_resume");
        press_start();
        check("resume");
        run_ticks(2, "resume_count");
        press_clear();

        // Held start: one event only
        key(2); key(5);
        startN = 1'b0;
        cyc(1);
        m_state = M_COOK;
        check("hold_start_cook");
        door_closed = 1'b0;
        cyc(1);
        m_state = M_PAUSE;
        check("hold_start_pause");
        door_closed = 1'b1;
        cyc(6);
        check("hold_no_auto_resume");
        startN = 1'b1;
        cyc(1);
        press_start();
        check("resume_after_release");
        press_clear();

        // Clear beats start in the same cycle
        key(4); key(2);
        startN = 1'b0;
        clearN = 1'b0;
        cyc(1);
        startN = 1'b1;
        clearN = 1'b1;
        m_to_idle();
        check("clear_beats_start");

        // Randomized loads and partial cooks
        for (int r = 0; r < 8; r++) begin
            int d[4];
            if (r % 2 == 0) begin
                d = '{0, 0, 0, int'($urandom_range(0, 3))};
            end else begin
                for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 9));
            end
            for (int i = 0; i < 4; i++) key(d[i]);
            check("rand_load");
            press_start();
            check("rand_start");
            nt = int'($urandom_range(1, 8));
            run_ticks(nt, "rand_cook");
            press_clear();
            check("rand_clear");
        end

        // Asynchronous reset mid-cook
        key(5); key(0);
        press_start();
        cyc(2);
        rst = 1'b1;
        #2;
        m_to_idle();
        check("async_reset");
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
